// File: rtl/satalnk_txsched.sv
// SATA link TX scheduler: forwards link dwords to the PHY and inserts periodic ALIGN bursts.
// Latency: one cycle from s_valid && s_ready to m_data.
// Backpressure: m_ready low holds m_data; s_ready drops during ALIGN bursts, PHY stalls and link down.
// Optional macro SATALNK_TXCONT_EN enables CONT suppression of repeated primitives.
module satalnk_txsched #(
  parameter int ALIGN_INTERVAL = 254,
  parameter int ALIGN_COUNT    = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_phy_ready,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [32:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [32:0] m_data,
  output logic        o_align
);

  // Primitive encodings, bit 32 is the primitive (K-character) flag
  localparam logic [32:0] P_ALIGN   = {1'b1, 32'h7B4A4ABC};
  localparam logic [32:0] P_SYNC    = {1'b1, 32'hB5B5957C};
  localparam logic [32:0] P_CONT    = {1'b1, 32'h9999AA7C};
  localparam logic [32:0] P_HOLD    = {1'b1, 32'hD5D5AA7C};
  localparam logic [32:0] P_HOLDA   = {1'b1, 32'h9595AA7C};
  localparam logic [32:0] P_R_RDY   = {1'b1, 32'h4A4A957C};
  localparam logic [32:0] P_X_RDY   = {1'b1, 32'h5757B57C};
  localparam logic [32:0] P_R_IP    = {1'b1, 32'h5555B57C};
  localparam logic [32:0] P_R_OK    = {1'b1, 32'h3535B57C};
  localparam logic [32:0] P_R_ERR   = {1'b1, 32'h5656B57C};
  localparam logic [32:0] P_WTRM    = {1'b1, 32'h5858B57C};
  localparam logic [32:0] P_PMREQ_P = {1'b1, 32'h1717B57C};
  localparam logic [32:0] P_PMREQ_S = {1'b1, 32'h7575957C};

  typedef enum logic {S_PASS, S_ALIGN} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [8:0]  r_cnt;
  logic [1:0]  r_burst;
  logic        r_m_valid;
  logic [32:0] r_m_data;
  logic        r_align;
  logic [32:0] w_fwd;
  logic        w_load;
  logic        w_take;
  logic        w_last_int;
  logic        w_last_burst;
  logic [8:0]  w_cnt_inc;

  assign w_load       = !r_m_valid || m_ready;
  assign w_take       = s_valid && s_ready;
  assign w_last_int   = (r_cnt == 9'(ALIGN_INTERVAL - 1));
  assign w_last_burst = (r_burst == 2'(ALIGN_COUNT - 1));
  // Arithmetic saturates; the interval wraps only through the compare above
  assign w_cnt_inc    = (&r_cnt) ? r_cnt : r_cnt + 9'd1;

  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign o_align = r_align;

  // Next state and link-side ready
  always_comb begin
    w_state_nxt = r_state;
    s_ready     = (r_state == S_PASS) && w_load && i_phy_ready;
    if (!i_phy_ready) begin
      w_state_nxt = S_PASS;
    end else begin
      case (r_state)
        S_PASS:  if (w_take && w_last_int) w_state_nxt = S_ALIGN;
        S_ALIGN: if (w_load && w_last_burst) w_state_nxt = S_PASS;
        default: w_state_nxt = S_PASS;
      endcase
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_PASS;
    else         r_state <= w_state_nxt;
  end

  // Output register, interval and burst counters
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_m_valid <= 1'b0;
      r_m_data  <= P_SYNC;
      r_align   <= 1'b0;
      r_cnt     <= 9'd0;
      r_burst   <= 2'd0;
    end else if (!i_phy_ready) begin
      r_cnt   <= 9'd0;
      r_align <= 1'b0;
      if (w_load) r_m_valid <= 1'b0;
    end else if (r_state == S_PASS) begin
      if (w_take) begin
        r_m_data  <= w_fwd;
        r_m_valid <= 1'b1;
        if (w_last_int) begin
          r_cnt   <= 9'd0;
          r_burst <= 2'd0;
          r_align <= 1'b1;
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end else if (w_load) begin
        r_m_valid <= 1'b0;
      end
    end else begin
      if (w_load) begin
        r_m_data  <= P_ALIGN;
        r_m_valid <= 1'b1;
        r_burst   <= r_burst + 2'd1;
        if (w_last_burst) r_align <= 1'b0;
      end
    end
  end

`ifdef SATALNK_TXCONT_EN
  logic [32:0] r_last;
  logic [1:0]  r_rep;
  logic [31:0] r_lfsr;
  logic        w_rptbl;
  logic        w_match;
  logic [31:0] w_lfsr_nxt;

  // Galois LFSR, x^32+x^22+x^2+x+1, shifting right
  assign w_lfsr_nxt = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? 32'h80200003 : 32'h0);
  assign w_match    = w_rptbl && (s_data == r_last);

  // Primitives that may be replaced by CONT when repeated
  always_comb begin
    w_rptbl = 1'b0;
    case (s_data)
      P_HOLD, P_HOLDA, P_SYNC, P_R_RDY, P_X_RDY, P_R_IP, P_R_OK,
      P_R_ERR, P_WTRM, P_PMREQ_P, P_PMREQ_S: w_rptbl = 1'b1;
      default: w_rptbl = 1'b0;
    endcase
  end

  // r_rep counts consecutive sends of r_last: 3rd becomes CONT, later ones junk
  always_comb begin
    w_fwd = s_data;
    if (w_match) begin
      case (r_rep)
        2'd2:    w_fwd = P_CONT;
        2'd3:    w_fwd = {1'b0, r_lfsr};
        default: w_fwd = s_data;
      endcase
    end
  end

  // Repeat tracking; an ALIGN burst or link drop forces the primitive to be resent
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last <= 33'd0;
      r_rep  <= 2'd0;
      r_lfsr <= 32'hC2D2768D;
    end else if (!i_phy_ready || r_state == S_ALIGN) begin
      r_rep <= 2'd0;
    end else if (w_take && s_data != P_ALIGN) begin
      r_last <= s_data;
      if (w_match) begin
        if (r_rep != 2'd3) r_rep <= r_rep + 2'd1;
        else               r_lfsr <= w_lfsr_nxt;
      end else begin
        r_rep <= 2'd1;
      end
    end
  end
`else
  assign w_fwd = s_data;
`endif

endmodule

// File: doc/satalnk_txsched.md
Name: satalnk_txsched

Overview:
- Scheduler between the link-layer state machine's TX stream and the PHY TX port.
- Shares the single PHY TX dword slot between link traffic and mandatory ALIGN bursts:
  - forwards link dwords through one registered stage;
  - every ALIGN_INTERVAL forwarded dwords, stalls the link and inserts ALIGN_COUNT P_ALIGN primitives.
- Optionally performs CONT suppression of repeated primitives.

Parameters:
- ALIGN_INTERVAL, 254, link dwords loaded between ALIGN bursts (2..511).
- ALIGN_COUNT, 2, P_ALIGN primitives per burst (1..3).

Ports:
- i_clk  input  1  TX clock
- i_reset  input  1  synchronous, active-high reset
- i_phy_ready  input  1  PHY link up; low restarts the interval count
- s_valid  input  1  link dword valid
- s_ready  output  1  link dword accepted this cycle
- s_data  input  33  link dword; bit 32 = primitive flag (sata_primitives.vh encoding)
- m_valid  output  1  PHY dword valid
- m_ready  input  1  PHY accepts dword
- m_data  output  33  PHY dword
- o_align  output  1  high while an ALIGN burst is being loaded

Behaviour:
- Reset values:
  - m_valid = 0, m_data = P_SYNC, o_align = 0;
  - state = S_PASS, interval count = 0, burst count = 0.
- load = !m_valid || m_ready: the output register may take a new word.
- s_ready = (state == S_PASS) && load && i_phy_ready (combinational).
- Latency: s_data appears on m_data one cycle after its s_valid && s_ready handshake.
- AXI-stream rules apply: m_data is held stable while m_valid && !m_ready.

State S_PASS:
- When s_valid && s_ready:
  - m_data <= s_data (or the CONT substitution, see Optional Feature), m_valid <= 1;
  - interval count += 1.
- When load && !s_valid: m_valid <= 0.
- When the load happens with count == ALIGN_INTERVAL-1:
  - count <= 0, burst count <= 0;
  - state <= S_ALIGN, o_align <= 1.

State S_ALIGN:
- s_ready = 0.
- Each load: m_data <= P_ALIGN, m_valid <= 1, burst count += 1.
- On the load with burst count == ALIGN_COUNT-1: state <= S_PASS, o_align <= 0.
- The first link dword after the burst is accepted in the cycle after the last ALIGN load.

Boundary conditions:
- ALIGNs are never interleaved mid-handshake: a stalled word (m_valid && !m_ready) is held until taken.
- Interval count saturates arithmetic at 9 bits and wraps only through the == compare.
- i_phy_ready low:
  - count <= 0, state <= S_PASS, o_align <= 0;
  - m_valid <= 0 on the next load;
  - s_ready = 0.
- i_reset overrides everything, including mid-burst and mid-stall.
- s_valid dropping mid-interval: count holds; no ALIGN is inserted until the interval completes.

Optional Feature:
- Macro: SATALNK_TXCONT_EN.
- With the macro defined, CONT suppression is active:
  - Repeatable set: P_HOLD, P_HOLDA, P_SYNC, P_R_RDY, P_X_RDY, P_R_IP, P_R_OK, P_R_ERR, P_WTRM, P_PMREQ_P, P_PMREQ_S.
  - Tracked state: last loaded link word, plus a 2-bit repeat count.
  - First and second consecutive identical repeatable primitives: sent unchanged.
  - Third: P_CONT is sent.
  - Further repeats: junk {1'b0, lfsr} is sent. The LFSR is 32-bit Galois, polynomial x^32+x^22+x^2+x+1, seed 32'hC2D2768D, advanced once per junk dword, reset to seed by i_reset.
  - Any different word, data dword, or non-repeatable primitive is sent as-is and resets the repeat count.
  - After an ALIGN burst the repeat count resets, so the primitive is re-sent twice before the next P_CONT.
  - P_ALIGN is never tracked.
- Without the macro: link words pass unmodified; no LFSR or tracking logic is synthesized.

Test Plan:
- ALIGN_INTERVAL=8, ALIGN_COUNT=2, s_valid=1, m_ready=1, data words 0..19 -> m_data = 0..7, P_ALIGN, P_ALIGN, 8..15, P_ALIGN, P_ALIGN, 16..19; s_ready low exactly on the 2 cycles of each burst.
- ALIGN_INTERVAL=8, m_ready low for 3 cycles while word 7 is on m_data -> word 7 held stable for all 3 cycles, then both ALIGNs, then word 8; no word lost or duplicated.
- i_reset asserted during the first ALIGN of a burst -> next cycle m_valid=0, o_align=0; after release, 8 link words pass before the next ALIGN.
- i_phy_ready low for 5 cycles after 5 link words -> s_ready=0 and m_valid drops; after recovery, 8 further words pass before an ALIGN.
- SATALNK_TXCONT_EN, link sends P_HOLD x6 then data 32'h1234 -> P_HOLD, P_HOLD, P_CONT, junk 32'hC2D2768D, next LFSR value, next LFSR value, then 32'h1234.
- SATALNK_TXCONT_EN, P_SYNC stream crossing an ALIGN burst -> after the burst P_SYNC, P_SYNC, then P_CONT.
